multicycle_controller: RTL and testbench

- Sequencing FSM for the multicycle RV32I core. Each instruction is sequenced through Fetch, Decode and opcode-specific execute/memory/writeback states over 3–5 cycles.
- Drives every datapath select and enable: PC, shared instruction/data memory, IR, register file, ALU muxes and the immediate extender's format select.
- Sits between the instruction register and the datapath. It replaces the single-cycle main decoder.

---
 rtl/multicycle_controller_pkg.sv | 40 ++++
 rtl/multicycle_controller_alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 161 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared opcodes, FSM state enum and ALU encodings for the multicycle RV32I controller.
// The JAL state exists only when MULTICYCLE_JAL_EN is defined.
package pa_riscv;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
`ifdef MULTICYCLE_JAL_EN
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
`else
    S_BEQ      = 4'd9
`endif
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational map from the internal aluOp and instruction funct fields to the ALU operation.
module alu_decoder
  import pa_riscv::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type sub from addi, which shares funct3=000
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core; drives all datapath selects and enables.
// MULTICYCLE_JAL_EN enables the JAL state and makes opcode 1101111 legal.
module multicycle_controller
  import pa_riscv::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  output logic       o_pcWrite,
  output logic       o_adrSrc,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic       o_regWrite,
  output logic [1:0] o_resultSrc,
  output logic [1:0] o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [1:0] o_immSrc,
  output logic [2:0] o_aluControl,
  output logic       o_illegal
);

  // state      | meaning
  // FETCH      | read instr at PC into IR, PC <= PC+4
  // DECODE     | read regs, ALUOut <= OldPC+imm (branch target)
  // MEMADR     | ALUOut <= rs1+imm
  // MEMREAD    | read data memory at ALUOut
  // MEMWB      | rd <= Data
  // MEMWRITE   | write rs2 to memory at ALUOut
  // EXECUTER   | ALUOut <= rs1 op rs2
  // EXECUTEI   | ALUOut <= rs1 op imm
  // ALUWB      | rd <= ALUOut
  // BEQ        | compare rs1-rs2, PC <= ALUOut on zero
  // JAL        | PC <= ALUOut, ALUOut <= OldPC+4

  state_t     state, state_next;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_FETCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = S_FETCH;
    o_adrSrc    = 1'b0;
    o_memWrite  = 1'b0;
    o_irWrite   = 1'b0;
    o_regWrite  = 1'b0;
    o_resultSrc = 2'b00;
    o_aluSrcA   = 2'b00;
    o_aluSrcB   = 2'b00;
    o_illegal   = 1'b0;
    alu_op      = ALUOP_ADD;
    pc_update   = 1'b0;
    branch      = 1'b0;
    case (state)
      S_FETCH: begin
        o_irWrite   = 1'b1;
        o_aluSrcB   = 2'b10;
        o_resultSrc = 2'b10;
        pc_update   = 1'b1;
        state_next  = S_DECODE;
      end
      S_DECODE: begin
        o_aluSrcA = 2'b01;
        o_aluSrcB = 2'b01;
        case (i_op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
`ifdef MULTICYCLE_JAL_EN
          OP_JAL:       state_next = S_JAL;
`endif
          default: begin
            state_next = S_FETCH;
            o_illegal  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        o_aluSrcA  = 2'b10;
        o_aluSrcB  = 2'b01;
        state_next = (i_op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        o_adrSrc   = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_resultSrc = 2'b01;
        o_regWrite  = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEMWRITE: begin
        o_adrSrc   = 1'b1;
        o_memWrite = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECUTER: begin
        o_aluSrcA  = 2'b10;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        o_aluSrcA  = 2'b10;
        o_aluSrcB  = 2'b01;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        o_regWrite = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        o_aluSrcA  = 2'b10;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
`ifdef MULTICYCLE_JAL_EN
      S_JAL: begin
        o_aluSrcA  = 2'b01;
        o_aluSrcB  = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
`endif
      default: state_next = S_FETCH;
    endcase
  end

  // The only input-to-enable combinational path: branch resolution on the zero flag
  assign o_pcWrite = pc_update | (branch & i_zero);

  always_comb begin
    o_immSrc = 2'b00;
    case (i_op)
      OP_SW:   o_immSrc = 2'b01;
      OP_BEQ:  o_immSrc = 2'b10;
`ifdef MULTICYCLE_JAL_EN
      OP_JAL:  o_immSrc = 2'b11;
`endif
      default: o_immSrc = 2'b00;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (i_funct3),
    .op5         (i_op[5]),
    .funct7b5    (i_funct7b5),
    .alu_control (o_aluControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control vectors from an instruction-level model.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  multicycle_controller dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_op         (op),
    .i_funct3     (funct3),
    .i_funct7b5   (funct7b5),
    .i_zero       (zero),
    .o_pcWrite    (pc_write),
    .o_adrSrc     (adr_src),
    .o_memWrite   (mem_write),
    .o_irWrite    (ir_write),
    .o_regWrite   (reg_write),
    .o_resultSrc  (result_src),
    .o_aluSrcA    (alu_src_a),
    .o_aluSrcB    (alu_src_b),
    .o_immSrc     (imm_src),
    .o_aluControl (alu_control),
    .o_illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc, aluSrcA, aluSrcB, immSrc, aluControl, illegal}
  logic [17:0] act;
  assign act = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, illegal};

  typedef struct {
    logic [17:0] vec;
    int          instr;
    int          step;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   instr_id = 0;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_JAL = 5, C_ILL = 6;
  localparam logic [2:0] A_ADD = 3'b000, A_SUB = 3'b001, A_AND = 3'b010, A_OR = 3'b011, A_SLT = 3'b101;

  function automatic int classify(input logic [6:0] o);
    case (o)
      7'b0000011: return C_LW;
      7'b0100011: return C_SW;
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b1100011: return C_BEQ;
`ifdef MULTICYCLE_JAL_EN
      7'b1101111: return C_JAL;
`endif
      default:    return C_ILL;
    endcase
  endfunction

  function automatic int cycles_of(input int c);
    case (c)
      C_LW:    return 5;
      C_SW, C_R, C_I, C_JAL: return 4;
      C_BEQ:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input int c);
    case (c)
      C_SW:    return 2'b01;
      C_BEQ:   return 2'b10;
      C_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // ALU operation implied by an R/I-type instruction's funct fields
  function automatic logic [2:0] arith_op(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (o[5] && f7) ? A_SUB : A_ADD;
      3'd2:    return A_SLT;
      3'd6:    return A_OR;
      3'd7:    return A_AND;
      default: return A_ADD;
    endcase
  endfunction

  function automatic logic [17:0] pack(input logic pc, input logic adr, input logic mw, input logic ir,
                                       input logic rw, input logic [1:0] rs, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] imm, input logic [2:0] alu,
                                       input logic ill);
    return {pc, adr, mw, ir, rw, rs, a, b, imm, alu, ill};
  endfunction

  function automatic logic [17:0] fetch_vec(input logic [6:0] o);
    return pack(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm_of(classify(o)), A_ADD, 0);
  endfunction

  // Expected controls for cycle 'step' (0 = fetch) of the instruction
  function automatic logic [17:0] model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                        input logic z, input int step);
    int c = classify(o);
    logic [1:0] im = imm_of(c);
    if (step == 0) return fetch_vec(o);
    if (step == 1) return pack(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, A_ADD, c == C_ILL);
    case (c)
      C_LW, C_SW: begin
        if (step == 2) return pack(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, A_ADD, 0);
        if (c == C_SW) return pack(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, A_ADD, 0);
        if (step == 3) return pack(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, A_ADD, 0);
        return pack(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, A_ADD, 0);
      end
      C_R, C_I: begin
        if (step == 2) return pack(0, 0, 0, 0, 0, 2'b00, 2'b10, (c == C_I) ? 2'b01 : 2'b00, im,
                                   arith_op(o, f3, f7), 0);
        return pack(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, A_ADD, 0);
      end
      C_BEQ: return pack(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, A_SUB, 0);
      C_JAL: begin
        if (step == 2) return pack(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, A_ADD, 0);
        return pack(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, A_ADD, 0);
      end
      default: return '0;
    endcase
  endfunction

  task automatic check_now(input string name, input logic [17:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %05h want %05h at %0t", name, act, want, $time);
    end
  endtask

  // Called at posedge+1: drives one instruction, queues its expectations, waits it out
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    int n;
    exp_t e;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    n = cycles_of(classify(o));
    for (int s = 0; s < n; s++) begin
      e.vec = model(o, f3, f7, z, s);
      e.instr = instr_id;
      e.step = s;
      sb.push_back(e);
    end
    instr_id++;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (act !== e.vec) begin
        n_fail++;
        $display("FAIL cycle instr=%0d step=%0d op=%07b: got %05h want %05h", e.instr, e.step, op, act, e.vec);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    logic [6:0] ops [8];
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b0010011;
    ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b0000000; ops[7] = 7'b1111111;

    rst_n = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    #2;
    check_now("reset_fetch_outputs", fetch_vec(op));
    repeat (3) @(posedge clk);
    #1;
    check_now("reset_held", fetch_vec(op));
    rst_n = 1'b1;

    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0);  // add after reset
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);  // lw
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0);  // sw
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1);  // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0);  // beq not taken
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0);  // sub
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0);  // addi with funct7b5 set
    run_instr(7'b0110011, 3'b010, 1'b0, 1'b0);  // slt
    run_instr(7'b0110011, 3'b110, 1'b0, 1'b0);  // or
    run_instr(7'b0010011, 3'b111, 1'b0, 1'b0);  // andi
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0);  // illegal
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b1);  // jal: legal or illegal per build

    for (int i = 0; i < 80; i++) begin
      logic [6:0] o;
      o = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) o = 7'($urandom);
      run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom));
    end

    // Abort during MEMWB: issue lw, stop after the MEMWB sample
    begin
      exp_t e;
      op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
      for (int s = 0; s < 5; s++) begin
        e.vec = model(op, funct3, funct7b5, zero, s);
        e.instr = instr_id;
        e.step = s;
        sb.push_back(e);
      end
      instr_id++;
      repeat (5) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_now("midreset_immediate", fetch_vec(op));
      repeat (2) begin
        @(negedge clk);
        check_now("midreset_held", fetch_vec(op));
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
      run_instr(7'b0110011, 3'b111, 1'b0, 1'b0);
    end

    repeat (2) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
